// File: rtl/mtimer_pkg.sv
// Shared constants for the machine timer: register word offsets, CTRL field
// positions and the byte-lane merge used by every writable register.
package mtimer_pkg;

   localparam logic [2:0] OFF_MTIME_LO    = 3'd0;
   localparam logic [2:0] OFF_MTIME_HI    = 3'd1;
   localparam logic [2:0] OFF_MTIMECMP_LO = 3'd2;
   localparam logic [2:0] OFF_MTIMECMP_HI = 3'd3;
   localparam logic [2:0] OFF_CTRL        = 3'd4;

   localparam int CTRL_EN_BIT  = 0;
   localparam int CTRL_DIV_LSB = 16;

   // Written lanes take the new byte, unwritten lanes keep the old one.
   function automatic logic [31:0] lane_merge(input logic [31:0] old_val,
                                              input logic [31:0] new_val,
                                              input logic [3:0]  sel);
      logic [31:0] res;
      for (int i = 0; i < 4; i++) begin
         res[i*8 +: 8] = sel[i] ? new_val[i*8 +: 8] : old_val[i*8 +: 8];
      end
      return res;
   endfunction

endpackage

// File: rtl/wb_if.sv
// Pipelined Wishbone B4 bus bundle with master and slave views.
interface wb_if;
   logic        cyc;
   logic        stb;
   logic        we;
   logic [31:0] adr;
   logic [3:0]  sel;
   logic [31:0] dat_m;
   logic [31:0] dat_s;
   logic        ack;
   logic        err;
   logic        stall;

   modport slave (
      input  cyc, stb, we, adr, sel, dat_m,
      output dat_s, ack, err, stall
   );

   modport master (
      output cyc, stb, we, adr, sel, dat_m,
      input  dat_s, ack, err, stall
   );
endinterface

// File: rtl/mtimer_prescaler.sv
// Divides the clock into a one-cycle tick every div+1 enabled cycles.
// A clear restarts the count without suppressing a tick already due.
module mtimer_prescaler #(
   parameter int PRESCALE_W = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  en,
   input  logic [PRESCALE_W-1:0] div,
   input  logic                  clr,
   output logic                  tick
);

   logic [PRESCALE_W-1:0] cnt;

   assign tick = en && (cnt == div);

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt <= '0;
      end else if (clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= (cnt == div) ? '0 : cnt + 1'b1;
      end
   end

endmodule

// File: rtl/wb_mtimer.sv
// RISC-V style machine timer (mtime/mtimecmp) behind a pipelined Wishbone
// slave, with a programmable prescaler and a level timer interrupt.
module wb_mtimer
   import mtimer_pkg::*;
#(
   parameter int PRESCALE_W = 16,
   parameter int RESET_DIV  = 99
) (
   input  logic clk,
   input  logic rst,
   wb_if.slave  wb,
   output logic irq_timer
);

   logic [63:0]           mtime;
   logic [63:0]           mtime_next;
   logic [63:0]           mtimecmp;
   logic [31:0]           shadow;
   logic                  en;
   logic [PRESCALE_W-1:0] div;
   logic                  ack;
   logic [31:0]           dat_q;
   logic [31:0]           rd_val;
   logic [31:0]           ctrl_word;
   logic [31:0]           ctrl_wr;
   logic                  tick;
   logic                  accept;
   logic                  wr_en;
   logic                  rd_en;
   logic [2:0]            off;
   logic                  unused_bits;

   // Handshake: a request is taken on any edge with cyc & stb & ~stall; ack
   // follows one cycle later for one cycle, and stall mirrors ack so at most
   // one request is ever outstanding.
   assign accept   = wb.cyc && wb.stb && !ack;
   assign wr_en    = accept && wb.we;
   assign rd_en    = accept && !wb.we;
   assign off      = wb.adr[4:2];
   assign wb.ack   = ack;
   assign wb.stall = ack;
   assign wb.err   = 1'b0;
   assign wb.dat_s = dat_q;

   assign unused_bits = ^{wb.adr[31:5], wb.adr[1:0],
                          ctrl_wr[CTRL_DIV_LSB-1:CTRL_EN_BIT+1]};

   mtimer_prescaler #(
      .PRESCALE_W(PRESCALE_W)
   ) u_prescaler (
      .clk (clk),
      .rst (rst),
      .en  (en),
      .div (div),
      .clr (wr_en && (off == OFF_CTRL)),
      .tick(tick)
   );

   always_comb begin
      ctrl_word                               = '0;
      ctrl_word[CTRL_EN_BIT]                  = en;
      ctrl_word[CTRL_DIV_LSB +: PRESCALE_W]   = div;
      ctrl_wr = lane_merge(ctrl_word, wb.dat_m, wb.sel);
   end

   // A write to either mtime half overrides the increment for that cycle, so
   // a tick never carries into or out of the half being written.
   always_comb begin
      mtime_next = mtime + {63'd0, tick};
      if (wr_en && (off == OFF_MTIME_LO)) begin
         mtime_next = {mtime[63:32], lane_merge(mtime[31:0], wb.dat_m, wb.sel)};
      end else if (wr_en && (off == OFF_MTIME_HI)) begin
         mtime_next = {lane_merge(mtime[63:32], wb.dat_m, wb.sel), mtime[31:0]};
      end
   end

   always_comb begin
      rd_val = '0;
      case (off)
         OFF_MTIME_LO:    rd_val = mtime[31:0];
         OFF_MTIME_HI:    rd_val = shadow;
         OFF_MTIMECMP_LO: rd_val = mtimecmp[31:0];
         OFF_MTIMECMP_HI: rd_val = mtimecmp[63:32];
         OFF_CTRL:        rd_val = ctrl_word;
         default:         rd_val = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         mtime     <= '0;
         mtimecmp  <= '1;
         shadow    <= '0;
         en        <= 1'b1;
         div       <= PRESCALE_W'(RESET_DIV);
         ack       <= 1'b0;
         dat_q     <= '0;
         irq_timer <= 1'b0;
      end else begin
         mtime     <= mtime_next;
         ack       <= accept;
         dat_q     <= rd_en ? rd_val : '0;
         irq_timer <= (mtime >= mtimecmp);
         // Reading the low half freezes the high half for a tear-free pair read.
         if (rd_en && (off == OFF_MTIME_LO)) begin
            shadow <= mtime[63:32];
         end
         if (wr_en) begin
            case (off)
               OFF_MTIMECMP_LO: mtimecmp[31:0]  <= lane_merge(mtimecmp[31:0], wb.dat_m, wb.sel);
               OFF_MTIMECMP_HI: mtimecmp[63:32] <= lane_merge(mtimecmp[63:32], wb.dat_m, wb.sel);
               OFF_CTRL: begin
                  en  <= ctrl_wr[CTRL_EN_BIT];
                  div <= ctrl_wr[CTRL_DIV_LSB +: PRESCALE_W];
               end
               default: ;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_wb_mtimer.sv
// Self-checking bench for wb_mtimer: bus driver tasks, read scoreboard with an
// expected queue, timing checks on ack/stall/irq and a one-line report.
module tb_wb_mtimer;

   localparam logic [2:0] LO = 3'd0, HI = 3'd1, CMP_LO = 3'd2, CMP_HI = 3'd3, CTRL = 3'd4;

   logic clk = 1'b0;
   logic rst;
   logic irq_timer;
   int   checks   = 0;
   int   failures = 0;
   logic [31:0] exp_q[$];

   wb_if bus();

   wb_mtimer #(
      .PRESCALE_W(16),
      .RESET_DIV (99)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .wb       (bus),
      .irq_timer(irq_timer)
   );

   // clock / reset block
   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   // driver: one complete bus cycle, with ack timing checked on the way
   task automatic xfer(input logic wr, input logic [2:0] off, input logic [31:0] d,
                       input logic [3:0] s, output logic [31:0] rdata);
      int n;
      @(negedge clk);
      bus.cyc   = 1'b1;
      bus.stb   = 1'b1;
      bus.we    = wr;
      bus.adr   = 32'h1002_0000 | {27'd0, off, 2'b00};
      bus.sel   = s;
      bus.dat_m = d;
      n = 0;
      while (bus.stall === 1'b1 && n < 8) begin
         @(negedge clk);
         n++;
      end
      @(posedge clk);
      #1;
      bus.cyc = 1'b0;
      bus.stb = 1'b0;
      bus.we  = 1'b0;
      n = 1;
      while (bus.ack !== 1'b1 && n < 8) begin
         @(posedge clk);
         #1;
         n++;
      end
      check_eq("ack_latency", 64'(n), 64'd1);
      check_eq("stall_in_ack", 64'(bus.stall), 64'd1);
      check_eq("err_zero", 64'(bus.err), 64'd0);
      rdata = bus.dat_s;
      @(posedge clk);
      #1;
      check_eq("ack_single", 64'(bus.ack), 64'd0);
      check_eq("dat_idle", 64'(bus.dat_s), 64'd0);
   endtask

   task automatic wr(input logic [2:0] off, input logic [31:0] d, input logic [3:0] s);
      logic [31:0] unused_rd;
      xfer(1'b1, off, d, s, unused_rd);
   endtask

   task automatic rd(input logic [2:0] off, output logic [31:0] v);
      xfer(1'b0, off, 32'd0, 4'hf, v);
   endtask

   // scoreboard: expectation queued when the read is issued, popped on ack
   task automatic rd_chk(input string tag, input logic [2:0] off, input logic [31:0] exp);
      logic [31:0] r;
      logic [31:0] e;
      exp_q.push_back(exp);
      rd(off, r);
      if (exp_q.size() == 0) begin
         check_eq({tag, "_queue_empty"}, 64'd1, 64'd0);
      end else begin
         e = exp_q.pop_front();
         check_eq(tag, 64'(r), 64'(e));
      end
   endtask

   initial begin
      logic [31:0] v;
      int n;
      bus.cyc = 1'b0; bus.stb = 1'b0; bus.we = 1'b0;
      bus.adr = '0; bus.sel = '0; bus.dat_m = '0;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      check_eq("rst_irq", 64'(irq_timer), 64'd0);
      check_eq("rst_ack", 64'(bus.ack), 64'd0);
      check_eq("rst_stall", 64'(bus.stall), 64'd0);
      check_eq("rst_dat", 64'(bus.dat_s), 64'd0);
      @(negedge clk);
      rst = 1'b0;

      // reset values of the register map
      rd_chk("rst_mtime_lo", LO, 32'h0);
      rd_chk("rst_mtime_hi", HI, 32'h0);
      rd_chk("rst_cmp_lo", CMP_LO, 32'hFFFF_FFFF);
      rd_chk("rst_cmp_hi", CMP_HI, 32'hFFFF_FFFF);
      rd_chk("rst_ctrl", CTRL, 32'h0063_0001);
      for (int i = 5; i < 8; i++) rd_chk("rst_unmapped", 3'(i), 32'h0);
      check_eq("rst_irq_after_reads", 64'(irq_timer), 64'd0);

      // byte lanes and unmapped offsets
      wr(CMP_LO, 32'hAABB_CCDD, 4'b0010);
      rd_chk("sel_cmp_lo", CMP_LO, 32'hFFFF_CCFF);
      rd_chk("sel_cmp_hi_kept", CMP_HI, 32'hFFFF_FFFF);
      wr(3'd7, 32'h1234_5678, 4'hf);
      rd_chk("unmapped_wr_rd", 3'd7, 32'h0);

      // prescaler off; shadow register behaviour
      wr(CTRL, 32'h0, 4'hf);
      rd_chk("ctrl_off", CTRL, 32'h0);
      wr(LO, 32'h5, 4'hf);
      wr(HI, 32'h7, 4'hf);
      rd_chk("shadow_stale", HI, 32'h0);
      rd_chk("mtime_lo_held", LO, 32'h5);
      rd_chk("shadow_capture", HI, 32'h7);

      // DIV 3 for 40 idle cycles: about ten ticks
      wr(LO, 32'h0, 4'hf);
      wr(HI, 32'h0, 4'hf);
      wr(CTRL, 32'h0003_0001, 4'hf);
      repeat (40) @(posedge clk);
      rd(LO, v);
      check_eq("div3_adv_in_range", 64'((v >= 32'd9) && (v <= 32'd11)), 64'd1);

      // carry from low to high half with DIV 0
      wr(CTRL, 32'h0, 4'hf);
      wr(LO, 32'hFFFF_FFFF, 4'hf);
      wr(HI, 32'h0, 4'hf);
      wr(CTRL, 32'h1, 4'hf);
      wr(CTRL, 32'h0, 4'hf);
      rd_chk("carry_lo", LO, 32'h1);
      rd_chk("carry_hi", HI, 32'h1);

      // full 64-bit wrap
      wr(LO, 32'hFFFF_FFFF, 4'hf);
      wr(HI, 32'hFFFF_FFFF, 4'hf);
      wr(CTRL, 32'h1, 4'hf);
      wr(CTRL, 32'h0, 4'hf);
      rd_chk("wrap_lo", LO, 32'h1);
      rd_chk("wrap_hi", HI, 32'h0);

      // write coinciding with a tick: no carry, unwritten lanes pre-increment
      wr(LO, 32'hFFFF_FFFE, 4'hf);
      wr(HI, 32'h0, 4'hf);
      wr(CTRL, 32'h1, 4'hf);
      wr(LO, 32'h0, 4'b0001);
      wr(CTRL, 32'h0, 4'hf);
      rd_chk("wr_tick_lo", LO, 32'hFFFF_FF02);
      rd_chk("wr_tick_hi", HI, 32'h0);

      // compare interrupt rise, hold and clear
      wr(LO, 32'h0, 4'hf);
      wr(HI, 32'h0, 4'hf);
      wr(CMP_LO, 32'h20, 4'hf);
      wr(CMP_HI, 32'h0, 4'hf);
      check_eq("irq_below", 64'(irq_timer), 64'd0);
      wr(CTRL, 32'h1, 4'hf);
      n = 1;
      while (irq_timer !== 1'b1 && n < 100) begin
         @(posedge clk);
         #1;
         n++;
      end
      check_eq("irq_rise_latency", 64'(n), 64'd33);
      repeat (3) @(posedge clk);
      #1;
      check_eq("irq_level_hold", 64'(irq_timer), 64'd1);
      wr(CMP_HI, 32'h1, 4'hf);
      check_eq("irq_clear", 64'(irq_timer), 64'd0);

      // reset arriving with a read request: no ack, registers back to reset
      @(negedge clk);
      rst     = 1'b1;
      bus.cyc = 1'b1;
      bus.stb = 1'b1;
      bus.we  = 1'b0;
      bus.adr = 32'h1002_0000;
      bus.sel = 4'hf;
      @(posedge clk);
      #1;
      bus.cyc = 1'b0;
      bus.stb = 1'b0;
      check_eq("rst_mid_ack", 64'(bus.ack), 64'd0);
      check_eq("rst_mid_irq", 64'(irq_timer), 64'd0);
      @(posedge clk);
      #1;
      check_eq("rst_mid_ack_late", 64'(bus.ack), 64'd0);
      check_eq("rst_mid_dat", 64'(bus.dat_s), 64'd0);
      @(negedge clk);
      rst = 1'b0;
      rd_chk("rst2_ctrl", CTRL, 32'h0063_0001);
      rd_chk("rst2_cmp_lo", CMP_LO, 32'hFFFF_FFFF);
      rd_chk("rst2_cmp_hi", CMP_HI, 32'hFFFF_FFFF);
      rd_chk("rst2_mtime_lo", LO, 32'h0);
      rd_chk("rst2_mtime_hi", HI, 32'h0);
      check_eq("rst2_irq", 64'(irq_timer), 64'd0);

      // final report
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
